gain_ramp_core: RTL

GAIN_RAMP_CORE -- requirements
Module: gain_ramp_core

---
 rtl/gain_pkg.sv | 34 +++
 rtl/gain_mac_sat.sv | 70 +++++++
 rtl/gain_ramp_core.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gain_pkg.sv
// Shared defaults, constants and the ramp-step helper for the gain ramp core.
package gain_pkg;

    localparam int unsigned DEF_DWIDTH = 16;
    localparam int unsigned DEF_GWIDTH = 16;
    localparam int unsigned DEF_FBITS  = 12;

    // Unity gain and output clamp limits at the default widths
    localparam logic signed [DEF_GWIDTH-1:0] UNITY_GAIN = DEF_GWIDTH'(1 << DEF_FBITS);
    localparam logic signed [DEF_DWIDTH-1:0] SAT_MAX    = DEF_DWIDTH'((1 << (DEF_DWIDTH - 1)) - 1);
    localparam logic signed [DEF_DWIDTH-1:0] SAT_MIN    = DEF_DWIDTH'(-(1 << (DEF_DWIDTH - 1)));

    // Move cur toward tgt by step without overshooting; step 0 jumps straight to tgt.
    // Operands are sign-extended into 64 bits so the intermediate sum never wraps.
    function automatic logic signed [63:0] ramp_step_clamp(
        input logic signed [63:0] cur,
        input logic signed [63:0] tgt,
        input logic signed [63:0] step
    );
        logic signed [63:0] nxt;
        nxt = cur;
        if (step == 64'sd0) begin
            nxt = tgt;
        end else if (cur < tgt) begin
            nxt = cur + step;
            if (nxt > tgt) nxt = tgt;
        end else if (cur > tgt) begin
            nxt = cur - step;
            if (nxt < tgt) nxt = tgt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gain_mac_sat.sv
// Two-stage multiply / round-half-up / saturate pipeline with a shared stall enable.
module gain_mac_sat
    import gain_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned GWIDTH = DEF_GWIDTH,
    parameter int unsigned FBITS  = DEF_FBITS,
    parameter int unsigned CW     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_adv,
    input  logic                     i_valid,
    input  logic signed [DWIDTH-1:0] i_data,
    input  logic signed [GWIDTH-1:0] i_gain,
    input  logic [CW-1:0]            i_chan,
    output logic                     o_valid,
    output logic signed [DWIDTH-1:0] o_data,
    output logic [CW-1:0]            o_chan,
    output logic                     o_sat_c
);

    localparam int unsigned PW = DWIDTH + GWIDTH;
    localparam logic signed [PW:0] RND = (FBITS == 0) ? '0 : (PW+1)'(64'(1) << (FBITS - 1));
    localparam logic signed [PW:0] HI  = (PW+1)'((64'sd1 <<< (DWIDTH - 1)) - 64'sd1);
    localparam logic signed [PW:0] LO  = (PW+1)'(-(64'sd1 <<< (DWIDTH - 1)));

    logic signed [PW-1:0]     r_prod;
    logic                     r_v1;
    logic [CW-1:0]            r_chan1;
    logic signed [PW:0]       w_rnd;
    logic signed [PW:0]       w_shr;
    logic                     w_hi;
    logic                     w_lo;
    logic signed [DWIDTH-1:0] w_sat;

    // Round the stage-1 product and clamp it to the output range
    always_comb begin
        w_rnd   = {r_prod[PW-1], r_prod} + RND;
        w_shr   = w_rnd >>> FBITS;
        w_hi    = w_shr > HI;
        w_lo    = w_shr < LO;
        w_sat   = w_hi ? HI[DWIDTH-1:0] : (w_lo ? LO[DWIDTH-1:0] : w_shr[DWIDTH-1:0]);
        o_sat_c = i_adv && r_v1 && (w_hi || w_lo);
    end

    // Stage 1 holds the product, stage 2 the final sample; both freeze on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_prod  <= '0;
            r_chan1 <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
        end else if (i_adv) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_prod  <= PW'(i_data) * PW'(i_gain);
                r_chan1 <= i_chan;
            end
            o_valid <= r_v1;
            if (r_v1) begin
                o_data <= w_sat;
                o_chan <= r_chan1;
            end
        end
    end

endmodule

// File: rtl/gain_ramp_core.sv
// Per-channel ramped gain stage: owns target/current gains, handshake and status flags.
module gain_ramp_core
    import gain_pkg::*;
#(
    parameter int unsigned DWIDTH    = DEF_DWIDTH,
    parameter int unsigned GWIDTH    = DEF_GWIDTH,
    parameter int unsigned FBITS     = DEF_FBITS,
    parameter int unsigned NCH       = 2,
    parameter int unsigned RAMP_STEP = 256,
    localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DWIDTH-1:0] s_data,
    input  logic [CW-1:0]            s_chan,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DWIDTH-1:0] m_data,
    output logic [CW-1:0]            m_chan,
    input  logic                     gain_we,
    input  logic [CW-1:0]            gain_ch,
    input  logic signed [GWIDTH-1:0] gain_wdata,
    output logic                     ramp_busy,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    localparam logic signed [GWIDTH-1:0] UNITY = GWIDTH'(64'(1) << FBITS);

    logic signed [GWIDTH-1:0] r_tgt [NCH];
    logic signed [GWIDTH-1:0] r_cur [NCH];
    logic                     r_busy;
    logic                     r_sat;
    logic                     w_adv;
    logic                     w_xfer;
    logic                     w_chan_ok;
    logic                     w_sat_set;
    logic                     w_any_diff;
    logic signed [GWIDTH-1:0] w_cur_sel;
    logic signed [GWIDTH-1:0] w_tgt_sel;
    logic signed [GWIDTH-1:0] w_cur_nxt;
    logic signed [GWIDTH-1:0] w_gain;

    assign w_adv     = !m_valid || m_ready;
    assign s_ready   = w_adv;
    assign w_xfer    = s_valid && w_adv;
    assign w_chan_ok = 32'(s_chan) < NCH;
    assign ramp_busy = r_busy;
    assign sat_flag  = r_sat;

    // Pick the addressed channel's gains, its next ramp value and the gain to apply
    always_comb begin
        w_cur_sel = UNITY;
        w_tgt_sel = UNITY;
        for (int i = 0; i < int'(NCH); i++) begin
            if (32'(s_chan) == 32'(i)) begin
                w_cur_sel = r_cur[i];
                w_tgt_sel = r_tgt[i];
            end
        end
        w_cur_nxt = GWIDTH'(ramp_step_clamp(64'(w_cur_sel), 64'(w_tgt_sel), 64'(RAMP_STEP)));
        w_gain    = (en && w_chan_ok) ? w_cur_sel : UNITY;
    end

    // Any channel still ramping
    always_comb begin
        w_any_diff = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (r_cur[i] != r_tgt[i]) w_any_diff = 1'b1;
        end
    end

    // Target writes and per-transfer ramp steps; the step always sees the pre-write target
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_tgt[i] <= UNITY;
                r_cur[i] <= UNITY;
            end
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (gain_we && (32'(gain_ch) == 32'(i))) r_tgt[i] <= gain_wdata;
                if (w_xfer && (32'(s_chan) == 32'(i))) r_cur[i] <= w_cur_nxt;
            end
        end
    end

    // Registered ramp-busy status
    always_ff @(posedge clk) begin
        if (rst) r_busy <= 1'b0;
        else     r_busy <= w_any_diff;
    end

    // Sticky saturation flag; a new clamp beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst)            r_sat <= 1'b0;
        else if (w_sat_set) r_sat <= 1'b1;
        else if (sat_clr)   r_sat <= 1'b0;
    end

    gain_mac_sat #(
        .DWIDTH (DWIDTH),
        .GWIDTH (GWIDTH),
        .FBITS  (FBITS),
        .CW     (CW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv),
        .i_valid (w_xfer),
        .i_data  (s_data),
        .i_gain  (w_gain),
        .i_chan  (s_chan),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_chan  (m_chan),
        .o_sat_c (w_sat_set)
    );

endmodule
